// File: rtl/ins_loader_pkg.sv
// Shared definitions for the boot-time instruction loader: FSM encodings,
// default geometry and the header validity rule.
package ins_loader_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_NWORDS = 256;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_HDR_HI = 3'd1,
    LD_HDR_LO = 3'd2,
    LD_DATA   = 3'd3,
    LD_WRITE  = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERR    = 3'd6
  } ld_state_e;

  // An image header is usable only if it names between 1 and max_words words.
  function automatic logic hdr_count_ok(input logic [CNT_W-1:0] n,
                                        input logic [31:0]      max_words);
    return (n != '0) && ({16'd0, n} <= max_words);
  endfunction

endpackage

// File: rtl/ins_loader_word_asm.sv
// Big-endian byte-to-word assembler: the 4th shifted byte completes a word,
// which is presented combinationally so the caller can register it on that edge.
module ld_word_asm (
  input  logic        CLK,
  input  logic        RST,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clr_i) begin
      idx_d = 2'd0;
    end else if (shift_i) begin
      shift_d = {shift_q[15:0], byte_i};
      idx_d   = idx_q + 2'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Oldest byte ends up in [31:24]; the current byte fills [7:0].
  assign word_o      = {shift_q, byte_i};
  assign word_full_o = shift_i && (idx_q == 2'd3);

endmodule

// File: rtl/ins_loader.sv
// Streams a length-prefixed image into instruction memory and keeps the core
// in reset until a complete, valid image has been written.
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NWORDS = DEF_NWORDS
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [31:0]       W_Ins,
  output logic              WE,
  output logic [ADDR_W-1:0] W_Addr,
  output logic              core_RST,
  output logic              busy,
  output logic              done,
  output logic              err
);

  ld_state_e         state_q, state_d;
  logic [7:0]        cnt_hi_q, cnt_hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [31:0]       w_ins_q, w_ins_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic              we_q, we_d;

  logic              xfer;
  logic [CNT_W-1:0]  hdr_count;
  logic              hdr_ok;
  logic              last_word;
  logic              asm_shift;
  logic              asm_clr;
  logic [31:0]       asm_word;
  logic              word_full;

  assign xfer      = byte_valid && byte_ready;
  assign hdr_count = {cnt_hi_q, byte_in};
  assign hdr_ok    = hdr_count_ok(hdr_count, 32'(NWORDS));
  assign last_word = (word_idx_q == (cnt_q - 16'd1));
  assign asm_shift = (state_q == LD_DATA) && xfer;
  assign asm_clr   = (state_q == LD_HDR_LO) && xfer && hdr_ok;

  ld_word_asm u_word_asm (
    .CLK         (CLK),
    .RST         (RST),
    .clr_i       (asm_clr),
    .shift_i     (asm_shift),
    .byte_i      (byte_in),
    .word_o      (asm_word),
    .word_full_o (word_full)
  );

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= LD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LD_IDLE:   if (start) state_d = LD_HDR_HI;
      LD_HDR_HI: if (xfer)  state_d = LD_HDR_LO;
      LD_HDR_LO: if (xfer)  state_d = hdr_ok ? LD_DATA : LD_ERR;
      LD_DATA:   if (word_full) state_d = LD_WRITE;
      LD_WRITE:  state_d = last_word ? LD_DONE : LD_DATA;
      LD_DONE:   if (start) state_d = LD_HDR_HI;
      LD_ERR:    if (start) state_d = LD_HDR_HI;
      default:   state_d = LD_IDLE;
    endcase
  end

  // Status outputs decode the current state only
  always_comb begin
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    core_RST   = 1'b0;
    unique case (state_q)
      LD_HDR_HI, LD_HDR_LO, LD_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      LD_WRITE: busy = 1'b1;
      LD_DONE: begin
        done     = 1'b1;
        core_RST = 1'b1;
      end
      LD_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: header capture, write port and word/address counters
  always_comb begin
    cnt_hi_d   = cnt_hi_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    w_ins_d    = w_ins_q;
    w_addr_d   = w_addr_q;
    we_d       = 1'b0;

    if ((state_q == LD_HDR_HI) && xfer) begin
      cnt_hi_d = byte_in;
    end

    if (asm_clr) begin
      cnt_d      = hdr_count;
      word_idx_d = '0;
      w_addr_d   = '0;
    end

    // WE and the word land on the same edge that accepts the 4th byte.
    if (word_full) begin
      w_ins_d = asm_word;
      we_d    = 1'b1;
    end

    // The address advances only after the write, so it is stable during WE.
    if ((state_q == LD_WRITE) && !last_word) begin
      word_idx_d = word_idx_q + 16'd1;
      w_addr_d   = w_addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_hi_q   <= '0;
      cnt_q      <= '0;
      word_idx_q <= '0;
      w_ins_q    <= '0;
      w_addr_q   <= '0;
      we_q       <= 1'b0;
    end else begin
      cnt_hi_q   <= cnt_hi_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      w_ins_q    <= w_ins_d;
      w_addr_q   <= w_addr_d;
      we_q       <= we_d;
    end
  end

  assign W_Ins  = w_ins_q;
  assign W_Addr = w_addr_q;
  assign WE     = we_q;

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: byte streams with hand-computed words,
// write-port scoreboard fed by a negedge monitor.
module tb_ins_loader;

  localparam int ADDR_W = 8;
  localparam int NWORDS = 256;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic [31:0]       W_Ins;
  logic              WE;
  logic [ADDR_W-1:0] W_Addr;
  logic              core_RST;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int failures = 0;
  int ready_in_write = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  logic [31:0]       wr_data_q[$];

  ins_loader #(.ADDR_W(ADDR_W), .NWORDS(NWORDS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .W_Ins      (W_Ins),
    .WE         (WE),
    .W_Addr     (W_Addr),
    .core_RST   (core_RST),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 CLK = ~CLK;

  // One line per memory write; WE must never coincide with byte_ready.
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      wr_addr_q.push_back(W_Addr);
      wr_data_q.push_back(W_Ins);
      if (byte_ready !== 1'b0) ready_in_write++;
      $display("WRITE addr=%0d data=%08h", W_Addr, W_Ins);
    end
  end

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Called on a negedge; returns on the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && t < 200) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout: byte_ready stayed %b, required 1 within 200 cycles", byte_ready);
    end
    @(negedge CLK);
    byte_valid = 1'b0;
    repeat (gap) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({byte_ready, WE, busy, done, err, core_RST} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got rdy/we/busy/done/err/core=%b required 000000",
               {byte_ready, WE, busy, done, err, core_RST});
    end
    checks++;
    if (W_Ins !== 32'h0 || W_Addr !== '0) begin
      failures++;
      $display("FAIL reset_port: got W_Ins=%08h W_Addr=%0d required 0/0", W_Ins, W_Addr);
    end
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b rdy=%b required 0/0", busy, byte_ready);
    end
  endtask

  task automatic test_single_word();
    clear_log();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || core_RST !== 1'b0) begin
      failures++;
      $display("FAIL single_hdr_state: got busy=%b rdy=%b core=%b required 1/1/0", busy, byte_ready, core_RST);
    end
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h2008_0005, 0);
    checks++;
    if (WE !== 1'b1 || W_Addr !== 8'd0 || W_Ins !== 32'h2008_0005 || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL single_write: got WE=%b addr=%0d data=%08h rdy=%b required 1/0/20080005/0",
               WE, W_Addr, W_Ins, byte_ready);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || core_RST !== 1'b1 || busy !== 1'b0 || WE !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got done=%b core=%b busy=%b WE=%b required 1/1/0/0", done, core_RST, busy, WE);
    end
    checks++;
    if (wr_addr_q.size() != 1) begin
      failures++;
      $display("FAIL single_we_count: got %0d required 1", wr_addr_q.size());
    end
  endtask

  task automatic test_restart_from_done();
    checks++;
    if (core_RST !== 1'b1) begin
      failures++;
      $display("FAIL done_core_before: got core=%b required 1", core_RST);
    end
    pulse_start();
    checks++;
    if (core_RST !== 1'b0 || done !== 1'b0 || busy !== 1'b1 || byte_ready !== 1'b1) begin
      failures++;
      $display("FAIL done_restart: got core=%b done=%b busy=%b rdy=%b required 0/0/1/1",
               core_RST, done, busy, byte_ready);
    end
  endtask

  task automatic test_stalled_stream();
    logic [31:0] exp_w [3] = '{32'h3C01_1001, 32'h3421_0004, 32'hAC22_0000};
    clear_log();
    ready_in_write = 0;
    send_byte(8'h00, 3);
    send_byte(8'h03, 3);
    for (int i = 0; i < 3; i++) send_word(exp_w[i], 3);
    checks++;
    if (wr_addr_q.size() != 3) begin
      failures++;
      $display("FAIL stall_we_count: got %0d required 3", wr_addr_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr_q.size()) begin
        checks++;
        if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== exp_w[i]) begin
          failures++;
          $display("FAIL stall_word%0d: got addr=%0d data=%08h required %0d/%08h",
                   i, wr_addr_q[i], wr_data_q[i], i, exp_w[i]);
        end
      end
    end
    checks++;
    if (ready_in_write != 0) begin
      failures++;
      $display("FAIL ready_in_write: got %0d cycles with byte_ready=1 during WE required 0", ready_in_write);
    end
    checks++;
    if (done !== 1'b1 || core_RST !== 1'b1) begin
      failures++;
      $display("FAIL stall_done: got done=%b core=%b required 1/1", done, core_RST);
    end
  endtask

  task automatic test_zero_count();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (err !== 1'b1 || core_RST !== 1'b0 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_err: got err=%b core=%b busy=%b rdy=%b required 1/0/0/0", err, core_RST, busy, byte_ready);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL zero_no_we: got %0d writes required 0", wr_addr_q.size());
    end
  endtask

  task automatic test_too_big();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    checks++;
    if (err !== 1'b1 || core_RST !== 1'b0) begin
      failures++;
      $display("FAIL big_err: got err=%b core=%b required 1/0", err, core_RST);
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (wr_addr_q.size() != 0) begin
      failures++;
      $display("FAIL big_no_we: got %0d writes required 0", wr_addr_q.size());
    end
  endtask

  task automatic test_err_recover();
    clear_log();
    pulse_start();
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL err_clear: got err=%b busy=%b required 0/1", err, busy);
    end
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h8C08_0004, 0);
    checks++;
    if (WE !== 1'b1 || W_Addr !== 8'd0 || W_Ins !== 32'h8C08_0004) begin
      failures++;
      $display("FAIL recover_write: got WE=%b addr=%0d data=%08h required 1/0/8c080004", WE, W_Addr, W_Ins);
    end
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || core_RST !== 1'b1) begin
      failures++;
      $display("FAIL recover_done: got done=%b err=%b core=%b required 1/0/1", done, err, core_RST);
    end
  endtask

  task automatic test_max_count();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    checks++;
    if (err !== 1'b0 || byte_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL max_accept: got err=%b rdy=%b busy=%b required 0/1/1", err, byte_ready, busy);
    end
    send_word(32'h0123_4567, 0);
    checks++;
    if (WE !== 1'b1 || W_Addr !== 8'd0 || W_Ins !== 32'h0123_4567) begin
      failures++;
      $display("FAIL max_write0: got WE=%b addr=%0d data=%08h required 1/0/01234567", WE, W_Addr, W_Ins);
    end
    @(negedge CLK);
    checks++;
    if (W_Addr !== 8'd1 || done !== 1'b0 || busy !== 1'b1 || WE !== 1'b0) begin
      failures++;
      $display("FAIL max_advance: got addr=%0d done=%b busy=%b WE=%b required 1/0/1/0", W_Addr, done, busy, WE);
    end
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'h1111_2222, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    #2;
    RST = 1'b0;
    #1;
    checks++;
    if ({byte_ready, WE, busy, done, err, core_RST} !== 6'b0 || W_Ins !== 32'h0 || W_Addr !== '0) begin
      failures++;
      $display("FAIL async_reset: got flags=%b W_Ins=%08h W_Addr=%0d required 000000/0/0",
               {byte_ready, WE, busy, done, err, core_RST}, W_Ins, W_Addr);
    end
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (4) @(negedge CLK);
    byte_valid = 1'b0;
    checks++;
    if (wr_addr_q.size() != 1 || (wr_addr_q.size() == 1 && (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'h1111_2222))) begin
      failures++;
      $display("FAIL partial_writes: got %0d writes required exactly one at addr 0 = 11112222", wr_addr_q.size());
    end
    RST = 1'b1;
    @(negedge CLK);
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hDEAD_BEEF, 0);
    send_word(32'h0000_000C, 0);
    @(negedge CLK);
    checks++;
    if (done !== 1'b1 || core_RST !== 1'b1) begin
      failures++;
      $display("FAIL reload_done: got done=%b core=%b required 1/1", done, core_RST);
    end
    checks++;
    if (wr_addr_q.size() != 2 ||
        (wr_addr_q.size() == 2 && (wr_addr_q[0] !== 8'd0 || wr_data_q[0] !== 32'hDEAD_BEEF ||
                                   wr_addr_q[1] !== 8'd1 || wr_data_q[1] !== 32'h0000_000C))) begin
      failures++;
      $display("FAIL reload_words: got %0d writes required 2 (0:deadbeef 1:0000000c)", wr_addr_q.size());
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_single_word();
    test_restart_from_done();
    test_stalled_stream();
    test_zero_count();
    test_too_big();
    test_err_recover();
    test_max_count();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
